// File: rtl/axil_regtest_master_if.sv
// rtl/axil_regtest_master_if.sv - AXI4-Lite bus bundle between the register-test master and its slave
interface axil_regtest_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    // write-address channel
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    // write-data channel
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    // write-response channel
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    // read-address channel
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    // read-data channel
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axil_regtest_master.sv
// rtl/axil_regtest_master.sv - AXI4-Lite master that writes, reads back and checks a register bank
module axil_regtest_master #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    NUM_REGS       = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    ADDR_STRIDE    = 4,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [7:0]            err_count,
    output logic [7:0]            first_err_idx,
    axil_regtest_master_if.master axi
);
    // Golden-ratio increments spread consecutive register patterns across all bits
    localparam logic [31:0] K32 = 32'h9E37_79B9;
    localparam logic [63:0] K64 = 64'h9E37_79B9_7F4A_7C15;
    localparam logic [DATA_WIDTH-1:0] K = (DATA_WIDTH == 64) ? DATA_WIDTH'(K64) : DATA_WIDTH'(K32);
    localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ADV, FIN
    } state_t;

    state_t                state, state_nx;
    logic                  aw_done, w_done;
    logic [7:0]            idx;
    logic [ADDR_WIDTH-1:0] addr_acc;
    logic [DATA_WIDTH-1:0] data_acc;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  mode_q;
    logic                  rd_pass;
    logic [TW-1:0]         tmo_cnt;
    logic                  pass_q;

    logic aw_ok, w_ok, tmo_hit, rd_bad, pass_now;
    logic rec_err, tmo_fire;

    // A channel counts as complete if it handshook earlier or handshakes this cycle
    assign aw_ok    = aw_done || (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY);
    assign w_ok     = w_done  || (axi.M_AXI_WVALID  && axi.M_AXI_WREADY);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign rd_bad   = (axi.M_AXI_RRESP != 2'b00) || (axi.M_AXI_RDATA != data_acc);
    assign pass_now = (err_count == 8'd0) && !timeout;

    assign axi.M_AXI_AWADDR = addr_acc;
    assign axi.M_AXI_ARADDR = addr_acc;
    assign axi.M_AXI_WDATA  = data_acc;
    assign axi.M_AXI_AWPROT = 3'b000;
    assign axi.M_AXI_ARPROT = 3'b000;
    assign axi.M_AXI_WSTRB  = '1;

    // pass is live during FIN so it is valid together with the done pulse
    assign pass = (state == FIN) ? pass_now : pass_q;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and bus handshake outputs
    always_comb begin
        state_nx          = state;
        busy              = 1'b0;
        done              = 1'b0;
        rec_err           = 1'b0;
        tmo_fire          = 1'b0;
        axi.M_AXI_AWVALID = 1'b0;
        axi.M_AXI_WVALID  = 1'b0;
        axi.M_AXI_BREADY  = 1'b0;
        axi.M_AXI_ARVALID = 1'b0;
        axi.M_AXI_RREADY  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WR_REQ;
                end
            end
            WR_REQ: begin
                busy              = 1'b1;
                axi.M_AXI_AWVALID = !aw_done;
                axi.M_AXI_WVALID  = !w_done;
                if (aw_ok && w_ok) begin
                    state_nx = WR_RESP;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_nx = FIN;
                end
            end
            WR_RESP: begin
                busy             = 1'b1;
                axi.M_AXI_BREADY = 1'b1;
                if (axi.M_AXI_BVALID) begin
                    rec_err  = (axi.M_AXI_BRESP != 2'b00);
                    state_nx = mode_q ? ADV : RD_REQ;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_nx = FIN;
                end
            end
            RD_REQ: begin
                busy              = 1'b1;
                axi.M_AXI_ARVALID = 1'b1;
                if (axi.M_AXI_ARREADY) begin
                    state_nx = RD_RESP;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_nx = FIN;
                end
            end
            RD_RESP: begin
                busy             = 1'b1;
                axi.M_AXI_RREADY = 1'b1;
                if (axi.M_AXI_RVALID) begin
                    rec_err  = rd_bad;
                    state_nx = ADV;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_nx = FIN;
                end
            end
            ADV: begin
                busy = 1'b1;
                if (idx != LAST_IDX) begin
                    state_nx = rd_pass ? RD_REQ : WR_REQ;
                end else if (mode_q && !rd_pass) begin
                    state_nx = RD_REQ;
                end else begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Per-phase watchdog restarts whenever the state changes
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tmo_cnt <= '0;
        end else if (state_nx != state) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Run context: index, address/data accumulators and write-channel progress
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            idx      <= 8'd0;
            addr_acc <= '0;
            data_acc <= '0;
            seed_q   <= '0;
            mode_q   <= 1'b0;
            rd_pass  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= 8'd0;
                        addr_acc <= BASE_ADDR;
                        data_acc <= seed;
                        seed_q   <= seed;
                        mode_q   <= mode;
                        rd_pass  <= 1'b0;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end
                end
                WR_REQ: begin
                    // flags clear themselves once both channels are through
                    aw_done <= aw_ok && !w_ok;
                    w_done  <= w_ok && !aw_ok;
                end
                ADV: begin
                    if (idx != LAST_IDX) begin
                        idx      <= idx + 8'd1;
                        addr_acc <= addr_acc + ADDR_WIDTH'(ADDR_STRIDE);
                        data_acc <= data_acc + K;
                    end else if (mode_q && !rd_pass) begin
                        // bulk read pass replays the write sequence from the top
                        rd_pass  <= 1'b1;
                        idx      <= 8'd0;
                        addr_acc <= BASE_ADDR;
                        data_acc <= seed_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result tracking: error count, first failing index, timeout and latched pass
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_count     <= 8'd0;
            first_err_idx <= 8'hFF;
            timeout       <= 1'b0;
            pass_q        <= 1'b0;
        end else if (state == IDLE && start) begin
            err_count     <= 8'd0;
            first_err_idx <= 8'hFF;
            timeout       <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            if (rec_err) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (first_err_idx == 8'hFF) begin
                    first_err_idx <= idx;
                end
            end
            if (tmo_fire) begin
                timeout <= 1'b1;
            end
            if (state == FIN) begin
                pass_q <= pass_now;
            end
        end
    end
endmodule
